// File: rtl/jt51_lfo_pkg.sv
// -----------------------------------------------------------------------------
// jt51_lfo_pkg
// Shared definitions for the LFO register front-end.
//
// Contents:
//   - CPU register addresses of the LFO block
//   - LFO waveform encodings
//   - default length of the write busy window
// -----------------------------------------------------------------------------
package jt51_lfo_pkg;

    localparam logic [7:0] LFO_TEST   = 8'h01;
    localparam logic [7:0] LFO_LFRQ   = 8'h18;
    localparam logic [7:0] LFO_DEPTH  = 8'h19;
    localparam logic [7:0] LFO_WAVE   = 8'h1B;
    localparam logic [7:0] LFO_STATUS = 8'hFF;

    typedef enum logic [1:0] {
        SAW    = 2'd0,
        SQUARE = 2'd1,
        TRI    = 2'd2,
        NOISE  = 2'd3
    } lfo_wave_e;

    localparam int unsigned BUSY_CYC_DEF = 64;

endpackage

// File: rtl/jt51_lfo_busy.sv
// -----------------------------------------------------------------------------
// jt51_lfo_busy
// Write acceptance and busy window. A write is accepted whenever wr is high
// and the window is closed, regardless of cen. The window then stays open
// for BUSY_CYC cen cycles.
//
// Ports:
//   i_clk     in   system clock
//   i_rst     in   asynchronous active-high reset
//   i_cen     in   clock enable for the window countdown
//   i_wr      in   single-clk write strobe
//   o_accept  out  combinational: this clk's write is taken
//   o_busy    out  registered busy flag
// -----------------------------------------------------------------------------
module jt51_lfo_busy
    import jt51_lfo_pkg::*;
#(
    parameter int unsigned BUSY_CYC = BUSY_CYC_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_cen,
    input  logic i_wr,
    output logic o_accept,
    output logic o_busy
);

    logic [7:0] r_cnt;
    logic       r_busy;

    assign o_accept = i_wr & ~r_busy;
    assign o_busy   = r_busy;

    // busy falls on the same cen edge that takes the count from 1 to 0,
    // so the flag is high for exactly BUSY_CYC cen cycles.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (o_accept) begin
            r_cnt  <= 8'(BUSY_CYC);
            r_busy <= 1'b1;
        end else if (r_busy && i_cen) begin
            r_cnt <= r_cnt - 8'd1;
            if (r_cnt == 8'd1) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/jt51_lfo_ctrl.sv
// -----------------------------------------------------------------------------
// jt51_lfo_ctrl
// Register front-end and timing sequencer for the LFO datapath. Decodes CPU
// writes, stages frequency/waveform until the per-sample zero pulse, and
// generates that pulse from a slot counter.
//
// Optional build macro: JT51_LFO_READBACK_EN (combinational readback mux on
// rd_dout; otherwise rd_dout is tied to zero).
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   cen          clock enable for slot counter and busy countdown
//   wr/addr/din  CPU write strobe, register address, write data
//   busy         write window open; writes dropped while high
//   zero         one-clk pulse once per sample
//   lfo_rst      LFO reset level (register 0x01 bit 1)
//   lfo_freq     committed LFRQ
//   lfo_amd      AM depth
//   lfo_pmd      PM depth
//   lfo_w        committed waveform
//   rd_dout      readback data
// -----------------------------------------------------------------------------
module jt51_lfo_ctrl
    import jt51_lfo_pkg::*;
#(
    parameter int unsigned BUSY_CYC = BUSY_CYC_DEF,
    parameter int unsigned SLOTS    = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       wr,
    input  logic [7:0] addr,
    input  logic [7:0] din,
    output logic       busy,
    output logic       zero,
    output logic       lfo_rst,
    output logic [7:0] lfo_freq,
    output logic [6:0] lfo_amd,
    output logic [6:0] lfo_pmd,
    output logic [1:0] lfo_w,
    output logic [7:0] rd_dout
);

    localparam logic [4:0] SLOT_LAST = 5'(SLOTS - 1);

    logic       w_accept;
    logic       w_busy;

    logic [4:0] r_slot;
    logic       r_zero;
    logic       r_lfo_rst;
    logic [7:0] r_freq_stg;
    lfo_wave_e  r_w_stg;
    logic [7:0] r_freq;
    lfo_wave_e  r_w;
    logic [6:0] r_amd;
    logic [6:0] r_pmd;

    jt51_lfo_busy #(
        .BUSY_CYC (BUSY_CYC)
    ) u_busy (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_cen    (cen),
        .i_wr     (wr),
        .o_accept (w_accept),
        .o_busy   (w_busy)
    );

    // zero is recomputed every clk so it can never stretch past one clk,
    // even when cen is low on the clk following the wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot <= '0;
            r_zero <= 1'b0;
        end else begin
            r_zero <= cen && (r_slot == SLOT_LAST);
            if (cen) begin
                r_slot <= (r_slot == SLOT_LAST) ? '0 : r_slot + 5'd1;
            end
        end
    end

    // Staging and commit share one edge: a write landing on the zero clk
    // updates the stage while the commit still takes the previous value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfo_rst  <= 1'b0;
            r_freq_stg <= '0;
            r_w_stg    <= SAW;
            r_freq     <= '0;
            r_w        <= SAW;
            r_amd      <= '0;
            r_pmd      <= '0;
        end else begin
            if (w_accept) begin
                case (addr)
                    LFO_TEST:  r_lfo_rst  <= din[1];
                    LFO_LFRQ:  r_freq_stg <= din;
                    LFO_DEPTH: begin
                        if (din[7]) r_pmd <= din[6:0];
                        else        r_amd <= din[6:0];
                    end
                    LFO_WAVE:  r_w_stg    <= lfo_wave_e'(din[1:0]);
                    default:   ;
                endcase
            end
            if (r_zero) begin
                r_freq <= r_freq_stg;
                r_w    <= r_w_stg;
            end
        end
    end

    assign busy     = w_busy;
    assign zero     = r_zero;
    assign lfo_rst  = r_lfo_rst;
    assign lfo_freq = r_freq;
    assign lfo_amd  = r_amd;
    assign lfo_pmd  = r_pmd;
    assign lfo_w    = r_w;

`ifdef JT51_LFO_READBACK_EN
    always_comb begin
        rd_dout = 8'h00;
        case (addr)
            LFO_TEST:   rd_dout = {6'd0, r_lfo_rst, 1'b0};
            LFO_LFRQ:   rd_dout = r_freq;
            LFO_DEPTH:  rd_dout = {1'b0, r_amd};
            LFO_WAVE:   rd_dout = {6'd0, r_w};
            LFO_STATUS: rd_dout = {w_busy, 7'd0};
            default:    rd_dout = 8'h00;
        endcase
    end
`else
    assign rd_dout = 8'h00;
`endif

endmodule

// File: doc/jt51_lfo_ctrl.md
Name: jt51_lfo_ctrl

Overview:
Register front-end and timing sequencer for the LFO datapath.
- Decodes CPU writes to the LFO registers (0x01 test, 0x18 LFRQ, 0x19 AMD/PMD, 0x1B waveform).
- Holds the configuration and drives lfo_freq, lfo_amd, lfo_pmd, lfo_w and lfo_rst.
- Generates the per-sample zero pulse from a 32-slot counter.
- Enforces a write busy window. Sits between the bus interface and the LFO datapath.

Parameters:
- BUSY_CYC, 64, number of cen cycles busy stays high after an accepted write (legal range 1..255).
- SLOTS, 32, slots per sample; the zero period. Must be a power of two, at most 32.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cen  in  1  clock enable; all state except the write capture advances only when high
- wr  in  1  single-clk write strobe
- addr  in  8  register address
- din  in  8  write data
- busy  out  1  write window open; writes dropped while high
- zero  out  1  one-clk pulse once per sample
- lfo_rst  out  1  LFO synchronous reset level
- lfo_freq  out  8  committed LFRQ
- lfo_amd  out  7  AM depth
- lfo_pmd  out  7  PM depth
- lfo_w  out  2  committed waveform
- rd_dout  out  8  readback data (only with the optional feature)

Behaviour:
- Reset (asynchronous, rst high): every output and internal register goes to 0. This includes busy, zero, slot counter, staged registers and busy counter.
- Slot counter: slot[4:0] increments by 1 on each clk with cen high and wraps SLOTS-1 -> 0.
  - zero is registered.
  - It is high for exactly one clk: the clk after a cen edge on which slot wrapped to 0.
  - It is never high on two consecutive clks.
- Write acceptance: a write is accepted when wr=1 and busy=0. Acceptance is independent of cen.
  - On acceptance, busy goes to 1 on the next clk and busy_cnt loads BUSY_CYC.
  - busy_cnt decrements on each cen while busy=1. busy drops the clk after busy_cnt reaches 0 on a cen.
  - A wr while busy=1 is ignored entirely; state is unchanged.
- Decode on accepted write:
  - 0x01: lfo_rst <= din[1], a level held until rewritten.
  - 0x18: freq_stg <= din.
  - 0x19 with din[7]=1: lfo_pmd <= din[6:0], effective next clk.
  - 0x19 with din[7]=0: lfo_amd <= din[6:0], effective next clk.
  - 0x1B: w_stg <= din[1:0]; din[7:2] is ignored.
  - Any other address: no register change, but busy is still asserted.
- Commit: on the clk where zero is high, lfo_freq <= freq_stg and lfo_w <= w_stg. This keeps frequency and waveform changes glitch-free relative to the LFO base counter.
  - Simultaneous accepted write and zero in the same clk: the commit uses the old staged value. The new value commits at the following zero.
- Writing lfo_rst=1 mid-operation leaves the slot counter and commit timing unaffected.
- Reset mid-write aborts the write; busy returns to 0.

Optional Feature:
- Macro: JT51_LFO_READBACK_EN.
- Enabled:
  - rd_dout is a combinational mux on addr:
    - 0x01 -> {6'd0, lfo_rst, 1'b0}
    - 0x18 -> lfo_freq, the committed value
    - 0x19 -> {1'b0, lfo_amd}
    - 0x1B -> {6'd0, lfo_w}
    - other addresses -> 8'h00
  - The status address 0xFF returns {busy, 7'd0}.
- Disabled: rd_dout is tied to 8'h00 and no mux logic is built.

Decomposition:
- Shared package jt51_lfo_pkg holds:
  - register address constants: LFO_TEST=8'h01, LFO_LFRQ=8'h18, LFO_DEPTH=8'h19, LFO_WAVE=8'h1B, LFO_STATUS=8'hFF;
  - waveform encodings: SAW=0, SQUARE=1, TRI=2, NOISE=3;
  - default BUSY_CYC.
- One natural sub-module, jt51_lfo_busy, containing the busy counter and accept logic. It takes wr, cen and the BUSY_CYC parameter, and outputs accept and busy.

Test Plan:
- Reset, then cen tied high for 100 clks -> zero pulses at clk 32, 64 and 96 (spacing 32); all config outputs read 0.
- Write 0x18=0xA5 at slot 5 -> lfo_freq stays 0x00 until the next zero, then becomes 0xA5. busy stays high for 64 cen cycles, then low.
- Write 0x19=0x85, wait for busy to clear, then write 0x19=0x12 -> lfo_pmd=0x05 and lfo_amd=0x12, each effective one clk after its accept.
- Write 0x1B=0xC2, then a second write 0x1B=0x01 issued 3 clks later (while busy) -> the second is dropped; lfo_w=2 after the next zero.
- Write 0x1B=0x03 landing on the same clk as zero -> lfo_w unchanged at that zero and =3 at the following zero.
- Assert rst mid-busy with lfo_rst=1 -> busy=0, lfo_rst=0 and slot=0 immediately. The first zero comes 32 cen cycles after rst is released.
